// File: rtl/pipe_skid_latch_pkg.sv
// Shared pipeline-latch definitions: default entry widths, control-field bit map
// and the occupancy encoding used by the two-entry skid latch.
package pipe_skid_latch_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int N_DATA_DEF  = 2;
    localparam int CTRL_W_DEF  = 5;
    localparam int SIDE_W_DEF  = 10;
    localparam int ENTRY_W_DEF = N_DATA_DEF * DATA_W_DEF + CTRL_W_DEF + SIDE_W_DEF;

    localparam int CTRL_REGWRITE    = 4;
    localparam int CTRL_MEMREAD     = 3;
    localparam int CTRL_MEMWRITE    = 2;
    localparam int CTRL_MEMTOREG_HI = 1;
    localparam int CTRL_MEMTOREG_LO = 0;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    // Control bits that a bubble must clear; with the standard map that is every bit.
    function automatic logic [CTRL_W_DEF-1:0] ctrl_bubble_mask();
        logic [CTRL_W_DEF-1:0] m;
        m = '0;
        m[CTRL_REGWRITE] = 1'b1;
        m[CTRL_MEMREAD]  = 1'b1;
        m[CTRL_MEMWRITE] = 1'b1;
        m[CTRL_MEMTOREG_HI:CTRL_MEMTOREG_LO] = '1;
        return m;
    endfunction

endpackage

// File: rtl/pipe_skid_latch_entry.sv
// One pipeline entry held in a load-enabled register; cleared by synchronous reset.
module pipe_entry_reg
    import pipe_skid_latch_pkg::*;
#(
    parameter int W = ENTRY_W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_skid_latch.sv
// Two-entry (head + skid) pipeline stage latch with flush-to-bubble, kill and a
// registered in_ready so upstream never sees a combinational path from out_ready.
//
// state     | meaning
// OCC_EMPTY | nothing held, out_valid low
// OCC_ONE   | head valid, skid free, in_ready high
// OCC_FULL  | head and skid valid, in_ready low
module pipe_skid_latch
    import pipe_skid_latch_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int N_DATA = N_DATA_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int SIDE_W = SIDE_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_DATA*DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0]        in_ctrl,
    input  logic [SIDE_W-1:0]        in_side,
    input  logic                     in_flush,
    input  logic                     kill,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_DATA*DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0]        out_ctrl,
    output logic [SIDE_W-1:0]        out_side,
    output logic [1:0]               count
);

    localparam int DW = N_DATA * DATA_W;
    localparam int EW = DW + CTRL_W + SIDE_W;

    localparam logic [CTRL_W-1:0] FLUSH_CLR =
        (CTRL_W == CTRL_W_DEF) ? CTRL_W'(ctrl_bubble_mask()) : {CTRL_W{1'b1}};

    occ_e          occ_q;
    occ_e          occ_d;
    occ_e          occ_eff;
    logic          rst_q;
    logic          accept;
    logic          pop;
    logic          head_load;
    logic          skid_load;
    logic          head_from_skid;
    logic [CTRL_W-1:0] ctrl_in_eff;
    logic [EW-1:0] in_entry;
    logic [EW-1:0] head_d;
    logic [EW-1:0] head_q;
    logic [EW-1:0] skid_q;

    // rst_q keeps in_ready low for the cycle that follows a reset edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q <= OCC_EMPTY;
            rst_q <= 1'b1;
        end else begin
            occ_q <= occ_d;
            rst_q <= 1'b0;
        end
    end

    // An unencoded occupancy value behaves as empty.
    always_comb begin
        occ_eff = OCC_EMPTY;
        case (occ_q)
            OCC_ONE:  occ_eff = OCC_ONE;
            OCC_FULL: occ_eff = OCC_FULL;
            default:  occ_eff = OCC_EMPTY;
        endcase
    end

    assign in_ready  = ~rst_q & (occ_eff != OCC_FULL);
    assign out_valid = (occ_eff != OCC_EMPTY);
    assign count     = occ_eff;
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        occ_d          = occ_eff;
        head_load      = 1'b0;
        skid_load      = 1'b0;
        head_from_skid = 1'b0;
        if (kill) begin
            occ_d = OCC_EMPTY;
        end else begin
            case (occ_eff)
                OCC_EMPTY: begin
                    if (accept) begin
                        occ_d     = OCC_ONE;
                        head_load = 1'b1;
                    end
                end
                OCC_ONE: begin
                    if (accept && pop) begin
                        head_load = 1'b1;
                    end else if (accept) begin
                        skid_load = 1'b1;
                        occ_d     = OCC_FULL;
                    end else if (pop) begin
                        occ_d = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (pop) begin
                        head_load      = 1'b1;
                        head_from_skid = 1'b1;
                        occ_d          = OCC_ONE;
                    end
                end
                default: occ_d = OCC_EMPTY;
            endcase
        end
    end

    assign ctrl_in_eff = in_flush ? (in_ctrl & ~FLUSH_CLR) : in_ctrl;
    assign in_entry    = {in_data, ctrl_in_eff, in_side};
    assign head_d      = head_from_skid ? skid_q : in_entry;

    pipe_entry_reg #(.W(EW)) u_head (
        .clk   (clk),
        .reset (reset),
        .load  (head_load),
        .d     (head_d),
        .q     (head_q)
    );

    pipe_entry_reg #(.W(EW)) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load),
        .d     (in_entry),
        .q     (skid_q)
    );

    assign out_data = head_q[EW-1 -: DW];
    assign out_ctrl = out_valid ? head_q[SIDE_W +: CTRL_W] : '0;
    assign out_side = head_q[SIDE_W-1:0];

endmodule
